// File: rtl/note_event_scheduler.sv
// Guitar-controller front end: synchronizes and debounces frets/strum/star-power,
// timestamps each strum and queues note events for software over an Avalon-MM slave.
module note_event_scheduler #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int TICK_CYCLES     = 50000,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       chipselect,
    input  logic [2:0] address,
    input  logic       read,
    input  logic       write,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    output logic       waitrequest,
    input  logic [5:0] GPIO_1,
    input  logic [3:0] KEY,
    output logic [7:0] LEDR
);

    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TK_W  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TK_W-1:0] TK_MAX = TK_W'(TICK_CYCLES - 1);
    localparam logic [4:0]      DEPTH  = 5'(FIFO_DEPTH);

    localparam logic [2:0] ADDR_STATUS = 3'd0;
    localparam logic [2:0] ADDR_EVENT  = 3'd1;
    localparam logic [2:0] ADDR_TS_LO  = 3'd2;
    localparam logic [2:0] ADDR_TS_HI  = 3'd3;
    localparam logic [2:0] ADDR_LIVE   = 3'd4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } rd_state_t;

    // Bit order everywhere in the input path: [6]=KEY[0], [5]=strum, [4:0]=frets.
    logic [6:0]      raw_s;
    logic [6:0]      sync1_r;
    logic [6:0]      sync2_r;
    logic [6:0]      deb_r;
    logic [DB_W-1:0] db_cnt_r [7];

    logic [TK_W-1:0] presc_r;
    logic [15:0]     ts_r;

    logic            strum_prev_r;
    logic            rise_s;
    logic            push_pend_r;
    logic [5:0]      push_data_r;
    logic [15:0]     push_ts_r;

    logic [5:0]       ev_mem_r [FIFO_DEPTH];
    logic [15:0]      ts_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [4:0]       count_r;
    logic             overflow_r;
    logic             empty_s;
    logic             full_s;
    logic [5:0]       head_ev_s;
    logic [15:0]      head_ts_s;

    logic            wr_ctrl_s;
    logic            flush_s;
    logic            ovf_clr_s;
    logic            push_s;
    logic            do_push_s;
    logic            do_pop_s;
    logic            ovf_set_s;

    rd_state_t       state_r;
    rd_state_t       state_nxt_s;
    logic            capture_s;
    logic            pop_pend_r;
    logic [7:0]      rd_mux_s;
    logic [7:0]      status_s;

    logic            unused_s;

    assign raw_s    = {KEY[0], GPIO_1};
    assign unused_s = &{1'b0, KEY[3:1], writedata[6:1]};
    assign LEDR     = {1'b0, deb_r};

    // Two-flop synchronizer for the asynchronous controller lines.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 7'd0;
            sync2_r <= 7'd0;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Per-bit debounce: accept a new level only after it has persisted DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_r <= 7'd0;
            for (int i = 0; i < 7; i++) begin
                db_cnt_r[i] <= {DB_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < 7; i++) begin
                if (sync2_r[i] == deb_r[i]) begin
                    db_cnt_r[i] <= {DB_W{1'b0}};
                end else if (db_cnt_r[i] == DB_MAX) begin
                    deb_r[i]    <= sync2_r[i];
                    db_cnt_r[i] <= {DB_W{1'b0}};
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
                end
            end
        end
    end

    // Millisecond-style timestamp: prescaler wrap advances the free-running 16-bit ts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_r <= {TK_W{1'b0}};
            ts_r    <= 16'd0;
        end else if (presc_r == TK_MAX) begin
            presc_r <= {TK_W{1'b0}};
            ts_r    <= ts_r + 16'd1;
        end else begin
            presc_r <= presc_r + TK_W'(1);
        end
    end

    assign rise_s = deb_r[5] & ~strum_prev_r;

    // Strum rising-edge detect; chord and ts are frozen in the edge cycle, pushed one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            strum_prev_r <= 1'b0;
            push_pend_r  <= 1'b0;
            push_data_r  <= 6'd0;
            push_ts_r    <= 16'd0;
        end else begin
            strum_prev_r <= deb_r[5];
            push_pend_r  <= rise_s;
            if (rise_s) begin
                push_data_r <= {deb_r[6], deb_r[4:0]};
                push_ts_r   <= ts_r;
            end
        end
    end

    assign empty_s   = (count_r == 5'd0);
    assign full_s    = (count_r == DEPTH);
    assign head_ev_s = ev_mem_r[rd_ptr_r];
    assign head_ts_s = ts_mem_r[rd_ptr_r];

    assign wr_ctrl_s = chipselect & write & (address == ADDR_STATUS);
    assign flush_s   = wr_ctrl_s & writedata[0];
    assign ovf_clr_s = wr_ctrl_s & writedata[7];

    // A flush overrides both a pending push and a pending pop; a pop frees room for a push.
    assign push_s    = push_pend_r & ~flush_s;
    assign do_pop_s  = (state_r == ST_ACK) & pop_pend_r & ~flush_s & ~empty_s;
    assign do_push_s = push_s & (~full_s | do_pop_s);
    assign ovf_set_s = push_s & full_s & ~do_pop_s;

    // Event storage; written only on an accepted push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                ev_mem_r[i] <= 6'd0;
                ts_mem_r[i] <= 16'd0;
            end
        end else if (do_push_s) begin
            ev_mem_r[wr_ptr_r] <= push_data_r;
            ts_mem_r[wr_ptr_r] <= push_ts_r;
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= 5'd0;
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= (overflow_r & ~ovf_clr_s) | ovf_set_s;
            if (flush_s) begin
                wr_ptr_r <= {PTR_W{1'b0}};
                rd_ptr_r <= {PTR_W{1'b0}};
                count_r  <= 5'd0;
            end else begin
                if (do_push_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                end
                if (do_pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                end
                if (do_push_s && !do_pop_s) begin
                    count_r <= count_r + 5'd1;
                end else if (do_pop_s && !do_push_s) begin
                    count_r <= count_r - 5'd1;
                end
            end
        end
    end

    // Read handshake state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Read handshake next state: one wait cycle in IDLE, data presented in ACK.
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        waitrequest = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (chipselect && read) begin
                    waitrequest = 1'b1;
                    capture_s   = 1'b1;
                    state_nxt_s = ST_ACK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACK: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign status_s = {overflow_r, empty_s, full_s, count_r};

    // Register map read mux; head-entry registers read as zero on an empty FIFO.
    always_comb begin
        rd_mux_s = 8'h00;
        case (address)
            ADDR_STATUS: rd_mux_s = status_s;
            ADDR_EVENT: begin
                if (empty_s) begin
                    rd_mux_s = 8'h00;
                end else begin
                    rd_mux_s = {2'b00, head_ev_s};
                end
            end
            ADDR_TS_LO: begin
                if (empty_s) begin
                    rd_mux_s = 8'h00;
                end else begin
                    rd_mux_s = head_ts_s[7:0];
                end
            end
            ADDR_TS_HI: begin
                if (empty_s) begin
                    rd_mux_s = 8'h00;
                end else begin
                    rd_mux_s = head_ts_s[15:8];
                end
            end
            ADDR_LIVE: rd_mux_s = {1'b0, deb_r};
            default:   rd_mux_s = 8'h00;
        endcase
    end

    // Read data capture; the pop decision is latched with it so ACK pops exactly what was read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readdata   <= 8'h00;
            pop_pend_r <= 1'b0;
        end else if (capture_s) begin
            readdata   <= rd_mux_s;
            pop_pend_r <= (address == ADDR_EVENT) & ~empty_s;
        end else begin
            pop_pend_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_note_event_scheduler.sv
// Directed bench for note_event_scheduler: scoreboard of expected note events,
// Avalon read/write tasks and immediate-assertion checks.
module tb_note_event_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       chipselect = 1'b0;
    logic [2:0] address = 3'd0;
    logic       read = 1'b0;
    logic       write = 1'b0;
    logic [7:0] writedata = 8'h00;
    logic [7:0] readdata;
    logic       waitrequest;
    logic [5:0] GPIO_1 = 6'd0;
    logic [3:0] KEY = 4'd0;
    logic [7:0] LEDR;

    int errors = 0;
    int checks = 0;
    int cyc;

    typedef struct packed {
        logic [15:0] ts;
        logic [5:0]  ev;
    } ev_t;

    ev_t sb[$];
    int  mcount = 0;
    bit  movf = 1'b0;

    note_event_scheduler #(
        .DEBOUNCE_CYCLES(4),
        .TICK_CYCLES(2),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .chipselect(chipselect),
        .address(address),
        .read(read),
        .write(write),
        .writedata(writedata),
        .readdata(readdata),
        .waitrequest(waitrequest),
        .GPIO_1(GPIO_1),
        .KEY(KEY),
        .LEDR(LEDR)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; ts at edge n is n/2 for TICK_CYCLES=2.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic rd(input logic [2:0] a, input bit keep, output logic [7:0] d);
        int waits;
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
        waits = 0;
        #1;
        while (waitrequest === 1'b1 && waits < 8) begin
            @(negedge clk);
            waits++;
        end
        chk("rd.wait_cycles", 16'(waits), 16'd1);
        d = readdata;
        if (!keep) begin
            @(negedge clk);
            chipselect = 1'b0; read = 1'b0;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; read = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    function automatic logic [7:0] model_status();
        return {movf, (mcount == 0), (mcount == 4), 5'(mcount)};
    endfunction

    // Raw press at edge count c0: debounced rise at edge c0+6, ts sampled just after it.
    task automatic press(input logic [4:0] fr, input logic k, input bit concurrent_pop);
        @(negedge clk);
        GPIO_1 = {1'b1, fr};
        KEY = {3'b000, k};
        if (mcount < 4 || concurrent_pop) begin
            sb.push_back({16'((cyc + 6) / 2), k, fr});
            mcount++;
        end else begin
            movf = 1'b1;
        end
    endtask

    task automatic release_all();
        @(negedge clk);
        GPIO_1 = 6'd0;
        KEY = 4'd0;
        repeat (8) @(negedge clk);
    endtask

    task automatic strum(input logic [4:0] fr, input logic k);
        press(fr, k, 1'b0);
        repeat (10) @(negedge clk);
        release_all();
    endtask

    task automatic check_event(input string tag);
        logic [7:0] lo, hi, ev;
        ev_t e;
        rd(3'd2, 1'b1, lo);
        rd(3'd3, 1'b1, hi);
        rd(3'd1, 1'b0, ev);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            mcount--;
        end else begin
            e = '{ts: 16'd0, ev: 6'd0};
        end
        chk({tag, ".ts"}, {hi, lo}, e.ts);
        chk({tag, ".event"}, {8'h00, ev}, {10'd0, e.ev});
    endtask

    initial begin
        logic [7:0] d, lo, hi;
        ev_t e;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.readdata", {8'h00, readdata}, 16'h0000);
        chk("rst.waitrequest", {15'd0, waitrequest}, 16'h0000);
        chk("rst.ledr", {8'h00, LEDR}, 16'h0000);
        reset = 1'b1;
        rd(3'd0, 1'b0, d);
        chk("rst.status", {8'h00, d}, 16'h0040);

        // Single strum: debounce timing on LEDR, count not yet visible before edge 8
        press(5'b00101, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        chk("t1.ledr_before", {8'h00, LEDR}, 16'h0000);
        @(negedge clk);
        chk("t1.ledr_after", {8'h00, LEDR}, 16'h0025);
        rd(3'd0, 1'b0, d);
        chk("t1.status_edge8", {8'h00, d}, 16'h0040);
        rd(3'd0, 1'b0, d);
        chk("t1.status_one", {8'h00, d}, 16'h0001);
        check_event("t1");
        rd(3'd0, 1'b0, d);
        chk("t1.status_drained", {8'h00, d}, 16'h0040);
        release_all();

        // Second strum with KEY[0]: entry visible in a STATUS captured at edge 9
        press(5'b10000, 1'b1, 1'b0);
        repeat (7) @(negedge clk);
        rd(3'd0, 1'b0, d);
        chk("t1b.status_edge9", {8'h00, d}, 16'h0001);
        rd(3'd4, 1'b0, d);
        chk("t1b.live", {8'h00, d}, 16'h0070);
        check_event("t1b");
        release_all();

        // 3-cycle glitch on strum
        @(negedge clk);
        GPIO_1 = 6'b100000;
        repeat (3) @(negedge clk);
        GPIO_1 = 6'd0;
        repeat (10) @(negedge clk);
        chk("t2.ledr", {8'h00, LEDR}, 16'h0000);
        rd(3'd4, 1'b0, d);
        chk("t2.live", {8'h00, d}, 16'h0000);
        rd(3'd0, 1'b0, d);
        chk("t2.status", {8'h00, d}, 16'h0040);

        // Six strums into a depth-4 FIFO
        for (int i = 0; i < 6; i++) begin
            strum(5'(i + 1), 1'(i % 2));
        end
        rd(3'd0, 1'b0, d);
        chk("t3.status_ovf", {8'h00, d}, 16'h00A4);
        wr(3'd0, 8'h80);
        movf = 1'b0;
        rd(3'd0, 1'b0, d);
        chk("t3.status_cleared", {8'h00, d}, 16'h0024);

        // Pop of the head coincident with a push into a full FIFO
        rd(3'd2, 1'b1, lo);
        rd(3'd3, 1'b0, hi);
        press(5'b11111, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        rd(3'd1, 1'b0, d);
        e = sb.pop_front();
        mcount--;
        chk("t4.head_ts", {hi, lo}, e.ts);
        chk("t4.head_event", {8'h00, d}, {10'd0, e.ev});
        rd(3'd0, 1'b0, d);
        chk("t4.status", {8'h00, d}, 16'h0024);
        release_all();
        for (int i = 0; i < 4; i++) begin
            check_event($sformatf("t4.drain%0d", i));
        end
        rd(3'd0, 1'b0, d);
        chk("t4.status_empty", {8'h00, d}, {8'h00, model_status()});

        // EVENT read on empty FIFO, then flush with three entries
        rd(3'd1, 1'b0, d);
        chk("t5.empty_event", {8'h00, d}, 16'h0000);
        rd(3'd0, 1'b0, d);
        chk("t5.status_empty", {8'h00, d}, 16'h0040);
        for (int i = 0; i < 3; i++) begin
            strum(5'(5'd20 + 5'(i)), 1'b0);
        end
        rd(3'd0, 1'b0, d);
        chk("t5.status_three", {8'h00, d}, {8'h00, model_status()});
        wr(3'd0, 8'h01);
        sb.delete();
        mcount = 0;
        rd(3'd0, 1'b0, d);
        chk("t5.status_flushed", {8'h00, d}, 16'h0040);

        // Reset in the middle of an ACK with strum and KEY[0] held
        press(5'b00011, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        rd(3'd0, 1'b1, d);
        chk("t6.status_pre", {8'h00, d}, 16'h0001);
        reset = 1'b0;
        chipselect = 1'b0;
        read = 1'b0;
        #1;
        chk("t6.rst_readdata", {8'h00, readdata}, 16'h0000);
        chk("t6.rst_waitrequest", {15'd0, waitrequest}, 16'h0000);
        chk("t6.rst_ledr", {8'h00, LEDR}, 16'h0000);
        sb.delete();
        mcount = 0;
        movf = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        // Inputs still held: the strum is re-debounced from edge 0 of the new run.
        sb.push_back({16'((0 + 6) / 2), 1'b1, 5'b00011});
        mcount = 1;
        rd(3'd0, 1'b0, d);
        chk("t6.status_after", {8'h00, d}, 16'h0040);
        repeat (10) @(negedge clk);
        check_event("t6");
        release_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/note_event_scheduler.md
# note_event_scheduler

Controller that sits between the guitar controller inputs (GPIO_1 frets/strum, KEY[0]) and the HPS Avalon bus. It synchronizes and debounces the raw inputs and timestamps every strum with the current fret chord. It queues the resulting note events in a small FIFO that software drains over an 8-bit Avalon-MM slave with waitrequest. This replaces live level polling, so software no longer misses strums between polls.

## Interface
- DEBOUNCE_CYCLES, 50000: consecutive cycles a synchronized input must differ from its debounced value before the debounced value changes; legal range ≥2.
- TICK_CYCLES, 50000: clk cycles per timestamp tick (1 ms at 50 MHz); legal range ≥1.
- FIFO_DEPTH, 8: event entries; power of two, legal range 2..16.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- chipselect  in  1  Avalon slave select.
- address  in  3  register select.
- read  in  1  Avalon read strobe; held by master until waitrequest low.
- write  in  1  Avalon write strobe (single cycle, no wait).
- writedata  in  8  write data.
- readdata  out  8  registered read data.
- waitrequest  out  1  Avalon wait.
- GPIO_1  in  6  raw controller lines; [4:0] frets, [5] strum; asynchronous.
- KEY  in  4  board keys; only KEY[0] used (star-power button); asynchronous.
- LEDR  out  8  {1'b0, deb_key0, deb_gpio[5:0]}.

## Operation
- Input path, per bit (7 bits: GPIO_1[5:0], KEY[0]):
  - 2-flop synchronizer, then debounce counter.
  - The counter clears when sync equals the debounced value; otherwise it increments.
  - When the counter is at DEBOUNCE_CYCLES-1 and sync still differs, the debounced value takes sync and the counter clears.
- Timestamp:
  - Prescaler counts 0..TICK_CYCLES-1.
  - The 16-bit ts increments when the prescaler wraps; ts wraps 0xFFFF→0x0000.
- Event generation: the rising edge of debounced strum (registered previous value) produces one push.
  - Push entry: {key0, frets[4:0]} in 6 bits, plus the ts sampled in the cycle of the edge.
  - The falling edge of strum produces nothing.
- FIFO:
  - Circular buffer with rd/wr pointers and a count of 0..FIFO_DEPTH.
  - Push when full: event dropped, sticky overflow set, contents unchanged.
  - Simultaneous push and pop (including when full): both occur, count unchanged, no overflow.
- Register map (read):
  - 0 STATUS: {overflow, empty, full, count[4:0]}.
  - 1 EVENT: {2'b00, key0, frets} of head entry; **pops** the head.
  - 2 TS_LO: head ts[7:0]; no pop.
  - 3 TS_HI: head ts[15:8]; no pop.
  - 4 LIVE: {1'b0, deb_key0, deb_gpio}.
  - 5–7: 0x00.
  - Software reads TS_LO, TS_HI, then EVENT.
- Reads of 1/2/3 when empty return 0x00; EVENT does not pop and no error is raised.
- Writes:
  - Address 0, writedata[7]=1 clears overflow.
  - Address 0, writedata[0]=1 flushes the FIFO (pointers and count to 0).
  - Other writes are ignored.
  - A flush coincident with a push: the flush wins and the push is dropped without setting overflow.
- Read handshake FSM states:
  - IDLE: chipselect&read → waitrequest=1; capture readdata from current state → ACK.
  - ACK: waitrequest=0, readdata valid; the pop (address 1, non-empty) happens in this cycle, exactly once → IDLE.
  - A master that deasserts read early in ACK still gets its pop.
- Reset (asserted at any time, including mid-read): all outputs and state clear immediately.
  - readdata=0x00, waitrequest=0, LEDR=0x00.
  - Debounced values 0, counters 0, ts 0, FIFO empty, overflow 0, FSM IDLE.

## Timing
- Raw input edge to debounced change: exactly 2+DEBOUNCE_CYCLES cycles if the input is held stable.
- Debounced strum rise to entry visible in STATUS.count: 2 cycles (edge register, push).
- Read latency: 2 cycles per access (1 wait, 1 data); back-to-back reads are allowed from the cycle after ACK.
- waitrequest is combinational from chipselect&read&IDLE; readdata is registered and holds its value until the next ACK.
- Pops take effect at the end of the ACK cycle; a STATUS read in the following transaction reflects the pop.
- Glitches shorter than DEBOUNCE_CYCLES produce no debounced change and no event.

## Test plan
(All scenarios use DEBOUNCE_CYCLES=4, TICK_CYCLES=2, FIFO_DEPTH=4.)
- Reset, then hold GPIO_1=6'b100101 → STATUS.count=1 at cycle 8 after the edge; EVENT reads 0x05, TS matches tick count; STATUS=0x40 afterward.
- Strum pulse of 3 cycles → no debounced change, LIVE stays 0x00, count stays 0.
- Six strums with no reads → STATUS=0xA4 (overflow, full, count 4); the first four events are retained in order; write 0x80 to address 0 → STATUS=0x24.
- Pop (EVENT read) in the same cycle as a strum push with FIFO full → count stays 4, overflow stays 0.
- EVENT read on empty FIFO → waitrequest high 1 cycle, readdata 0x00, count stays 0; write 0x01 with 3 entries → STATUS=0x40.
- Hold strum high with KEY[0] high across a read, then assert reset mid-ACK → readdata=0x00, waitrequest=0, LEDR=0x00, STATUS after release=0x40, ts restarts at 0.
